// File: rtl/ysyx_lsu_l1d.sv
// Load/store unit with a direct-mapped, write-through, no-write-allocate L1D.
// One BIT_W word per line; loads are aligned and extended here, uncacheable
// addresses go straight to the bus, stores always go to the bus and merge
// into the line only on a valid tag hit.
module ysyx_lsu_l1d #(
  parameter int BIT_W   = 32,
  parameter int L1D_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIT_W-1:0] addr,
  input  logic             ren,
  input  logic             wen,
  input  logic             lsu_avalid,
  input  logic [3:0]       alu_op,
  input  logic [BIT_W-1:0] wdata,
  input  logic             fence_i,
  output logic [BIT_W-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             wready_o,
  output logic [BIT_W-1:0] lsu_araddr_o,
  output logic             lsu_arvalid_o,
  output logic [7:0]       lsu_rstrb_o,
  input  logic [BIT_W-1:0] lsu_rdata,
  input  logic             lsu_rvalid,
  output logic [BIT_W-1:0] lsu_awaddr_o,
  output logic             lsu_awvalid_o,
  output logic [BIT_W-1:0] lsu_wdata_o,
  output logic [7:0]       lsu_wstrb_o,
  output logic             lsu_wvalid_o,
  input  logic             lsu_wready,
  output logic [31:0]      perf_hit_o,
  output logic [31:0]      perf_miss_o
);

  localparam int unsigned SETS  = 1 << L1D_LEN;
  localparam int          TAG_W = BIT_W - L1D_LEN - 2;

  localparam logic [3:0] YSYX_ALU_OP_LB  = 4'b0000;
  localparam logic [3:0] YSYX_ALU_OP_LH  = 4'b0001;
  localparam logic [3:0] YSYX_ALU_OP_LW  = 4'b0010;
  localparam logic [3:0] YSYX_ALU_OP_LBU = 4'b0100;
  localparam logic [3:0] YSYX_ALU_OP_LHU = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_RD,
    S_RESP,
    S_WR
  } state_t;

  state_t state_q, state_d;

  logic [BIT_W-1:0] addr_q;
  logic [BIT_W-1:0] wdata_q;
  logic [BIT_W-1:0] rdata_q;
  logic [3:0]       op_q;
  logic             rvalid_q;
  logic             pend_q;
  logic [31:0]      hit_cnt_q;
  logic [31:0]      miss_cnt_q;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [BIT_W-1:0] line_q [SETS];

  logic [L1D_LEN-1:0] req_idx, cur_idx;
  logic [TAG_W-1:0]   req_tag, cur_tag;
  logic               req_cacheable, cur_cacheable;
  logic               req_hit, cur_hit;
  logic               accept, to_idle, flush;

  function automatic logic is_cacheable(input logic [BIT_W-1:0] a);
    return (a >= BIT_W'(32'h3000_0000) && a < BIT_W'(32'h4000_0000)) ||
           (a >= BIT_W'(32'h8000_0000) && a < BIT_W'(32'h8040_0000)) ||
           (a >= BIT_W'(32'ha000_0000) && a < BIT_W'(32'hc000_0000));
  endfunction

  function automatic logic [7:0] rstrb_of(input logic [3:0] op);
    case (op)
      YSYX_ALU_OP_LB, YSYX_ALU_OP_LBU: return 8'h01;
      YSYX_ALU_OP_LH, YSYX_ALU_OP_LHU: return 8'h03;
      YSYX_ALU_OP_LW:                  return 8'h0f;
      default:                         return 8'h00;
    endcase
  endfunction

  function automatic logic [BIT_W-1:0] load_ext(input logic [BIT_W-1:0] w,
                                                input logic [1:0]       off,
                                                input logic [3:0]       op);
    logic [BIT_W-1:0] s;
    s = w >> {off, 3'b000};
    case (op)
      YSYX_ALU_OP_LB:  return {{(BIT_W-8){s[7]}}, s[7:0]};
      YSYX_ALU_OP_LBU: return {{(BIT_W-8){1'b0}}, s[7:0]};
      YSYX_ALU_OP_LH:  return {{(BIT_W-16){s[15]}}, s[15:0]};
      YSYX_ALU_OP_LHU: return {{(BIT_W-16){1'b0}}, s[15:0]};
      YSYX_ALU_OP_LW:  return s;
      default:         return '0;
    endcase
  endfunction

  assign req_idx       = addr[L1D_LEN+1:2];
  assign req_tag       = addr[BIT_W-1:L1D_LEN+2];
  assign cur_idx       = addr_q[L1D_LEN+1:2];
  assign cur_tag       = addr_q[BIT_W-1:L1D_LEN+2];
  assign req_cacheable = is_cacheable(addr);
  assign cur_cacheable = is_cacheable(addr_q);
  assign req_hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cur_hit       = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

  assign accept  = (state_q == S_IDLE) && lsu_avalid && (ren || wen) && !fence_i;
  assign to_idle = (state_q != S_IDLE) && (state_d == S_IDLE);
  // A fence seen while busy (held or arriving on the final cycle) takes effect
  // on the edge back into IDLE, after any fill or merge of that access.
  assign flush   = ((state_q == S_IDLE) && fence_i) || (to_idle && (pend_q || fence_i));

  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign lsu_araddr_o = addr_q;
  assign lsu_awaddr_o = addr_q;
  assign lsu_wdata_o  = wdata_q;
  assign perf_hit_o   = hit_cnt_q;
  assign perf_miss_o  = miss_cnt_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and bus handshake outputs.
  always_comb begin
    state_d       = state_q;
    lsu_arvalid_o = 1'b0;
    lsu_rstrb_o   = '0;
    lsu_awvalid_o = 1'b0;
    lsu_wvalid_o  = 1'b0;
    lsu_wstrb_o   = '0;
    wready_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (wen)                            state_d = S_WR;
          else if (req_cacheable && req_hit)  state_d = S_HIT;
          else                                state_d = S_RD;
        end
      end
      S_HIT:  state_d = S_IDLE;
      S_RD: begin
        lsu_arvalid_o = 1'b1;
        lsu_rstrb_o   = rstrb_of(op_q);
        if (lsu_rvalid) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      S_WR: begin
        lsu_awvalid_o = 1'b1;
        lsu_wvalid_o  = 1'b1;
        lsu_wstrb_o   = {4'b0000, op_q};
        if (lsu_wready) begin
          wready_o = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latches, cache arrays, load result and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      op_q       <= '0;
      rvalid_q   <= 1'b0;
      pend_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      for (int unsigned i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
    end else begin
      rvalid_q <= 1'b0;

      if (accept) begin
        addr_q  <= addr;
        op_q    <= alu_op;
        wdata_q <= wdata;
        if (!wen && req_cacheable && !req_hit) miss_cnt_q <= miss_cnt_q + 32'd1;
      end

      case (state_q)
        S_HIT: begin
          rdata_q   <= load_ext(line_q[cur_idx], addr_q[1:0], op_q);
          rvalid_q  <= 1'b1;
          hit_cnt_q <= hit_cnt_q + 32'd1;
        end
        S_RD: begin
          if (lsu_rvalid) begin
            rdata_q  <= load_ext(lsu_rdata, addr_q[1:0], op_q);
            rvalid_q <= 1'b1;
            if (cur_cacheable) begin
              line_q[cur_idx]  <= lsu_rdata;
              tag_q[cur_idx]   <= cur_tag;
              valid_q[cur_idx] <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (lsu_wready && cur_hit) begin
            for (int unsigned b = 0; b < 4; b++) begin
              if (op_q[b]) line_q[cur_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
        end
        default: ;
      endcase

      if (state_q == S_IDLE || to_idle) pend_q <= 1'b0;
      else if (fence_i)                 pend_q <= 1'b1;

      if (flush) valid_q <= '0;
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_l1d.sv
// Directed bench for ysyx_lsu_l1d: hand-computed loads, stores, fences, reset.
module tb_ysyx_lsu_l1d;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        ren, wen, lsu_avalid;
  logic [3:0]  alu_op;
  logic [31:0] wdata;
  logic        fence_i;
  logic [31:0] rdata_o;
  logic        rvalid_o, wready_o;
  logic [31:0] lsu_araddr_o;
  logic        lsu_arvalid_o;
  logic [7:0]  lsu_rstrb_o;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_awaddr_o;
  logic        lsu_awvalid_o;
  logic [31:0] lsu_wdata_o;
  logic [7:0]  lsu_wstrb_o;
  logic        lsu_wvalid_o;
  logic        lsu_wready;
  logic [31:0] perf_hit_o, perf_miss_o;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_lsu_l1d #(.BIT_W(32), .L1D_LEN(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .ren(ren), .wen(wen),
    .lsu_avalid(lsu_avalid), .alu_op(alu_op), .wdata(wdata), .fence_i(fence_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .wready_o(wready_o),
    .lsu_araddr_o(lsu_araddr_o), .lsu_arvalid_o(lsu_arvalid_o), .lsu_rstrb_o(lsu_rstrb_o),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr_o(lsu_awaddr_o), .lsu_awvalid_o(lsu_awvalid_o), .lsu_wdata_o(lsu_wdata_o),
    .lsu_wstrb_o(lsu_wstrb_o), .lsu_wvalid_o(lsu_wvalid_o), .lsu_wready(lsu_wready),
    .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a one-cycle request; returns at the negedge after the accept edge.
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] op, input logic [31:0] wd);
    lsu_avalid = 1'b1; ren = r; wen = w; addr = a; alu_op = op; wdata = wd;
    @(negedge clk);
    lsu_avalid = 1'b0; ren = 1'b0; wen = 1'b0;
  endtask

  task automatic load_miss(input string tag, input logic [31:0] a, input logic [3:0] op,
                           input logic [31:0] bus, input logic [31:0] exp,
                           input logic [7:0] strb, input logic fence_mid);
    issue(1'b1, 1'b0, a, op, 32'h0);
    chk({tag, "_arvalid"}, {31'b0, lsu_arvalid_o}, 32'd1);
    chk({tag, "_araddr"}, lsu_araddr_o, a);
    chk({tag, "_rstrb"}, {24'b0, lsu_rstrb_o}, {24'b0, strb});
    fence_i = fence_mid;
    @(negedge clk);
    fence_i = 1'b0;
    chk({tag, "_arvalid_hold"}, {31'b0, lsu_arvalid_o}, 32'd1);
    chk({tag, "_rvalid_early"}, {31'b0, rvalid_o}, 32'd0);
    lsu_rvalid = 1'b1; lsu_rdata = bus;
    @(negedge clk);
    lsu_rvalid = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, rvalid_o}, 32'd1);
    chk({tag, "_rdata"}, rdata_o, exp);
    chk({tag, "_arvalid_drop"}, {31'b0, lsu_arvalid_o}, 32'd0);
    @(negedge clk);
    chk({tag, "_rvalid_pulse"}, {31'b0, rvalid_o}, 32'd0);
  endtask

  task automatic load_hit(input string tag, input logic [31:0] a, input logic [3:0] op,
                          input logic [31:0] exp);
    issue(1'b1, 1'b0, a, op, 32'h0);
    chk({tag, "_no_arvalid"}, {31'b0, lsu_arvalid_o}, 32'd0);
    chk({tag, "_rvalid_early"}, {31'b0, rvalid_o}, 32'd0);
    @(negedge clk);
    chk({tag, "_rvalid"}, {31'b0, rvalid_o}, 32'd1);
    chk({tag, "_rdata"}, rdata_o, exp);
    chk({tag, "_no_arvalid2"}, {31'b0, lsu_arvalid_o}, 32'd0);
    @(negedge clk);
    chk({tag, "_rvalid_pulse"}, {31'b0, rvalid_o}, 32'd0);
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [3:0] strb,
                       input logic [31:0] wd);
    issue(1'b0, 1'b1, a, strb, wd);
    chk({tag, "_awvalid"}, {31'b0, lsu_awvalid_o}, 32'd1);
    chk({tag, "_wvalid"}, {31'b0, lsu_wvalid_o}, 32'd1);
    chk({tag, "_awaddr"}, lsu_awaddr_o, a);
    chk({tag, "_wdata"}, lsu_wdata_o, wd);
    chk({tag, "_wstrb"}, {24'b0, lsu_wstrb_o}, {28'b0, strb});
    chk({tag, "_wready_early"}, {31'b0, wready_o}, 32'd0);
    lsu_wready = 1'b1;
    #1;
    chk({tag, "_wready"}, {31'b0, wready_o}, 32'd1);
    @(negedge clk);
    lsu_wready = 1'b0;
    chk({tag, "_awvalid_drop"}, {31'b0, lsu_awvalid_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; addr = '0; ren = 0; wen = 0; lsu_avalid = 0; alu_op = '0; wdata = '0;
    fence_i = 0; lsu_rdata = '0; lsu_rvalid = 0; lsu_wready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst_arvalid", {31'b0, lsu_arvalid_o}, 32'd0);
    chk("rst_awvalid", {31'b0, lsu_awvalid_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_hit", perf_hit_o, 32'd0);
    chk("rst_miss", perf_miss_o, 32'd0);

    // Fill then hit.
    load_miss("lw_fill", 32'h8000_0004, OP_LW, 32'hdead_beef, 32'hdead_beef, 8'h0f, 1'b0);
    chk("fill_miss_cnt", perf_miss_o, 32'd1);
    load_hit("lw_hit", 32'h8000_0004, OP_LW, 32'hdead_beef);
    chk("hit_cnt1", perf_hit_o, 32'd1);

    // Store-hit merge and extension.
    store("sb", 32'h8000_0004, 4'h2, 32'h0000_5500);
    load_hit("lw_merged", 32'h8000_0004, OP_LW, 32'hdead_55ef);
    load_hit("lb", 32'h8000_0005, OP_LB, 32'h0000_0055);
    load_hit("lh", 32'h8000_0006, OP_LH, 32'hffff_dead);
    load_hit("lbu", 32'h8000_0007, OP_LBU, 32'h0000_00de);
    load_hit("lhu", 32'h8000_0006, OP_LHU, 32'h0000_dead);
    chk("hit_cnt6", perf_hit_o, 32'd6);

    // Uncacheable and range boundaries.
    load_miss("unc1", 32'h1000_0000, OP_LW, 32'h1234_5678, 32'h1234_5678, 8'h0f, 1'b0);
    load_miss("unc2", 32'h1000_0000, OP_LW, 32'h9abc_def0, 32'h9abc_def0, 8'h0f, 1'b0);
    load_miss("unc_edge", 32'h8040_0000, OP_LW, 32'h0bad_cafe, 32'h0bad_cafe, 8'h0f, 1'b0);
    chk("unc_miss_cnt", perf_miss_o, 32'd1);
    chk("unc_hit_cnt", perf_hit_o, 32'd6);
    load_miss("top_fill", 32'hbfff_fffc, OP_LW, 32'hcafe_f00d, 32'hcafe_f00d, 8'h0f, 1'b0);
    load_hit("top_hit", 32'hbfff_fffc, OP_LW, 32'hcafe_f00d);
    chk("top_miss_cnt", perf_miss_o, 32'd2);
    chk("top_hit_cnt", perf_hit_o, 32'd7);

    // Conflict eviction on index 0.
    load_miss("ev_a", 32'h8000_0000, OP_LW, 32'h1111_1111, 32'h1111_1111, 8'h0f, 1'b0);
    load_hit("ev_a_hit", 32'h8000_0000, OP_LW, 32'h1111_1111);
    load_miss("ev_b", 32'h8000_0010, OP_LW, 32'h2222_2222, 32'h2222_2222, 8'h0f, 1'b0);
    load_miss("ev_a2", 32'h8000_0000, OP_LW, 32'h3333_3333, 32'h3333_3333, 8'h0f, 1'b0);
    load_hit("ev_other", 32'h8000_0004, OP_LW, 32'hdead_55ef);
    chk("ev_miss_cnt", perf_miss_o, 32'd5);
    chk("ev_hit_cnt", perf_hit_o, 32'd9);

    // Fence while a fill is in flight.
    load_miss("fn_fill", 32'h8000_0008, OP_LW, 32'h4444_4444, 32'h4444_4444, 8'h0f, 1'b1);
    load_miss("fn_refill", 32'h8000_0008, OP_LW, 32'h5555_5555, 32'h5555_5555, 8'h0f, 1'b0);
    chk("fn_miss_cnt", perf_miss_o, 32'd7);

    // Fence with a request in IDLE: flushed, accepted on the next cycle.
    fence_i = 1'b1; lsu_avalid = 1'b1; ren = 1'b1; addr = 32'h8000_0008; alu_op = OP_LW;
    @(negedge clk);
    chk("fi_noaccept", {31'b0, lsu_arvalid_o}, 32'd0);
    fence_i = 1'b0;
    @(negedge clk);
    lsu_avalid = 1'b0; ren = 1'b0;
    chk("fi_accept_miss", {31'b0, lsu_arvalid_o}, 32'd1);
    lsu_rvalid = 1'b1; lsu_rdata = 32'h7777_7777;
    @(negedge clk);
    lsu_rvalid = 1'b0;
    chk("fi_rvalid", {31'b0, rvalid_o}, 32'd1);
    chk("fi_rdata", rdata_o, 32'h7777_7777);
    chk("fi_miss_cnt", perf_miss_o, 32'd8);
    @(negedge clk);

    // Reset in the middle of a store with the bus acknowledging.
    issue(1'b0, 1'b1, 32'h8000_0008, 4'hf, 32'habcd_abcd);
    lsu_wready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; lsu_wready = 1'b0;
    chk("wrst_awvalid", {31'b0, lsu_awvalid_o}, 32'd0);
    chk("wrst_wvalid", {31'b0, lsu_wvalid_o}, 32'd0);
    chk("wrst_wready", {31'b0, wready_o}, 32'd0);
    chk("wrst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("wrst_hit", perf_hit_o, 32'd0);
    chk("wrst_miss", perf_miss_o, 32'd0);
    load_miss("post_rst_lb", 32'h8000_0009, OP_LB, 32'h6666_8066, 32'hffff_ff80, 8'h01, 1'b0);
    chk("post_rst_miss", perf_miss_o, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_lsu_l1d.md
# ysyx_lsu_l1d

Parametrised load/store unit with a direct-mapped, write-through, no-write-allocate L1 data cache, sitting between the EXU and the data-side bus arbiter. It replaces the single-cycle-hit, invalidate-on-store LSU with a registered FSM. The new behaviour is configurable set count, store-hit merge by byte strobe, `fence_i` invalidation, and hit/miss performance counters. Loads are aligned and sign/zero-extended here; uncacheable addresses bypass the cache.

## Interface
- `BIT_W`, 32: data/address width.
- `L1D_LEN`, 2: index bits; sets = 2**L1D_LEN, one BIT_W word per line, tag = addr[BIT_W-1:L1D_LEN+2].
- `clk` in 1: clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `addr` in BIT_W: request address.
- `ren` / `wen` in 1: load / store request type.
- `lsu_avalid` in 1: request valid.
- `alu_op` in 4: load type (`YSYX_ALU_OP_LB/LBU/LH/LHU/LW`); for stores, the byte strobe.
- `wdata` in BIT_W: store data, lane-aligned by EXU.
- `fence_i` in 1: invalidate all lines.
- `rdata_o` out BIT_W: extended load data.
- `rvalid_o` out 1: one-cycle load-done pulse.
- `wready_o` out 1: one-cycle store-done pulse.
- `lsu_araddr_o` out BIT_W, `lsu_arvalid_o` out 1, `lsu_rstrb_o` out 8: bus read request.
- `lsu_rdata` in BIT_W, `lsu_rvalid` in 1: bus read response.
- `lsu_awaddr_o` out BIT_W, `lsu_awvalid_o` out 1, `lsu_wdata_o` out BIT_W, `lsu_wstrb_o` out 8, `lsu_wvalid_o` out 1: bus write request.
- `lsu_wready` in 1: bus write done.
- `perf_hit_o`, `perf_miss_o` out 32: cacheable-load hit/miss counters.

## Operation
- States: IDLE, HIT, RD, RESP, WR.
- IDLE: a request is accepted when `lsu_avalid` & (`ren` | `wen`) and `fence_i` is low. On acceptance, latch addr, alu_op, wdata and type.
- Load, cacheable and tag hit goes to HIT. HIT: line data registered, `rvalid_o`=1, `perf_hit_o`++, then IDLE.
- Load miss or uncacheable goes to RD.
  - RD: `lsu_arvalid_o`=1 with the latched address and rstrb.
  - On `lsu_rvalid`, capture data. If cacheable, also write the line, set its tag and set valid.
  - Go to RESP, then `rvalid_o`=1 and IDLE.
  - `perf_miss_o` increments on entry to RD for cacheable addresses only.
- Store goes to WR.
  - WR: `lsu_awvalid_o`=`lsu_wvalid_o`=1, `lsu_wstrb_o`={4'b0, alu_op}, `lsu_wdata_o`=latched wdata.
  - On `lsu_wready`: `wready_o`=1 in that same cycle. If the line is valid with a matching tag, merge wdata into it byte-wise per strobe; the line stays valid. Misses do not allocate. Then IDLE.
- Cacheable ranges: [0x30000000,0x40000000), [0x80000000,0x80400000), [0xa0000000,0xc0000000).
- rstrb: LB/LBU=0x01, LH/LHU=0x03, LW=0x0f, other=0.
- Load data is shifted right by addr[1:0]×8 with zero fill, then sign- or zero-extended per alu_op. Unknown alu_op yields 0.
- `fence_i` in IDLE clears all valid bits that cycle, and no request is accepted that cycle. If `fence_i` arrives while busy, it is recorded pending and applied on the cycle of return to IDLE.
- A tag match with valid=0 is a miss.
- Counters wrap modulo 2^32.

## Timing
- Reset: state IDLE, all valid bits 0, pending flush 0, counters 0. All outputs are 0 except address/data buses, which follow their latches (also reset to 0).
- A request in the middle of an access is aborted by `rst`; no line is written that cycle.
- Hit latency: `rvalid_o` 2 cycles after the accept edge (IDLE→HIT→pulse).
- Miss latency: `rvalid_o` 1 cycle after the `lsu_rvalid` cycle.
- Store: `wready_o` is combinational with `lsu_wready` while in WR.
- `lsu_avalid` is ignored outside IDLE. The EXU drops it in the cycle after `rvalid_o`/`wready_o`; if it is held high, a new request is accepted.
- Bus request signals stay high, with stable address and data, until the response arrives. There is no timeout.
- `lsu_rvalid`/`lsu_wready` outside RD/WR are ignored.

## Test plan
- Reset, then LW 0x80000004 (miss, bus returns 0xdeadbeef) -> arvalid in RD, `rvalid_o` with 0xdeadbeef, `perf_miss_o`=1. Repeat the same LW -> no arvalid, `rvalid_o` 2 cycles after accept, `perf_hit_o`=1.
- After that fill: SB strobe 0x2, wdata 0x00005500 to 0x80000004 -> bus write issued. A subsequent LW hits and returns 0xdead55ef. LB at 0x80000005 -> 0x00000055. LH at 0x80000006 -> 0xffffdead.
- LW 0x10000000 (uncacheable) twice -> both go to the bus, counters unchanged.
- With L1D_LEN=2: fill 0x80000000, then 0x80000010 (same index, different tag) -> second is a miss and evicts. Reloading 0x80000000 is a miss.
- `fence_i` pulsed during RD -> the fill completes; on return to IDLE all lines are invalid and the next load of a filled address misses. `fence_i` together with `lsu_avalid` in IDLE -> request accepted the following cycle.
- `rst` asserted during WR with `lsu_wready` high -> no merge, state IDLE, outputs 0, counters 0.
